// File: rtl/des_sbox_hash_core.sv
// Byte-serial DES-S5 nibble hash with ROUNDS clocks per byte and a length-folded final round (HASH_IV_LOAD_EN adds iv_load/iv).
// Accept->next accept ROUNDS+1 clocks, last byte->digest_valid ROUNDS+2; msg_ready low while busy, digest held until taken.
module des_sbox_hash_core #(
  parameter int                   NIBBLES = 8,
  parameter int                   ROUNDS  = 4,
  parameter logic [4*NIBBLES-1:0] IV      = 32'h4B71DF03
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [7:0]           msg_byte,
  input  logic                 msg_last,
  output logic                 digest_valid,
  input  logic                 digest_ready,
  output logic [4*NIBBLES-1:0] digest
`ifdef HASH_IV_LOAD_EN
  ,
  input  logic                 iv_load,
  input  logic [4*NIBBLES-1:0] iv
`endif
);

  localparam int         DW    = 4 * NIBBLES;
  localparam int         LW    = 8 * NIBBLES;
  localparam logic [3:0] RLAST = 4'(ROUNDS - 1);

  // DES S5 rows, column 0 in the least significant nibble.
  localparam logic [63:0] S5_R0 = 64'h9E0DF3586BA714C2;
  localparam logic [63:0] S5_R1 = 64'h6893AF051D74C2BE;
  localparam logic [63:0] S5_R2 = 64'hE0365C9F87DAB124;
  localparam logic [63:0] S5_R3 = 64'h354A90F6D2E17C8B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ROUND,
    ST_FINAL,
    ST_OUT
  } state_t;

  function automatic logic [3:0] sbox5(input logic [5:0] x);
    logic [63:0] row;
    case ({x[5], x[0]})
      2'b00:   row = S5_R0;
      2'b01:   row = S5_R1;
      2'b10:   row = S5_R2;
      default: row = S5_R3;
    endcase
    return row[{x[4:1], 2'b00} +: 4];
  endfunction

  function automatic logic [5:0] m6(input logic [7:0] m);
    return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
  endfunction

  function automatic logic [5:0] c6(input logic [7:0] c);
    return {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] v, input logic [1:0] k);
    logic [7:0] w;
    w = {v, v} << k;
    return w[7:4];
  endfunction

  // One round: every nibble takes its right-hand neighbour, keyed by its own S nibble.
  function automatic logic [DW-1:0] hash_round(input logic [DW-1:0] h, input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      r[DW-1-4*i -: 4] = rotl4(h[DW-1-4*((i+1)%NIBBLES) -: 4] ^ s[DW-1-4*i -: 4], 2'((i/2)%4));
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [DW-1:0] h_q, h_d;
  logic [DW-1:0] digest_q, digest_d;
  logic [LW-1:0] len_q, len_d;
  logic [3:0]    rcnt_q, rcnt_d;
  logic [3:0]    s_q, s_d;
  logic          last_q, last_d;
  logic          digest_valid_q, digest_valid_d;
  logic [DW-1:0] s_fin;

  always_comb begin
    s_fin = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      s_fin[DW-1-4*i -: 4] = sbox5(c6(len_q[LW-1-8*i -: 8]));
    end
  end

  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    digest_d       = digest_q;
    len_d          = len_q;
    rcnt_d         = rcnt_q;
    s_d            = s_q;
    last_d         = last_q;
    digest_valid_d = 1'b0;
    msg_ready      = 1'b0;

    case (state_q)
      ST_IDLE, ST_ACCEPT: begin
        msg_ready = 1'b1;
`ifdef HASH_IV_LOAD_EN
        if (state_q == ST_IDLE && iv_load) begin
          h_d = iv;
        end
`endif
        if (msg_valid) begin
          s_d     = sbox5(m6(msg_byte));
          last_d  = msg_last;
          len_d   = len_q + 1'b1;
          rcnt_d  = 4'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        h_d    = hash_round(h_q, {NIBBLES{s_q}});
        rcnt_d = rcnt_q + 4'd1;
        if (rcnt_q == RLAST) begin
          state_d = last_q ? ST_FINAL : ST_ACCEPT;
        end
      end
      ST_FINAL: begin
        digest_d = hash_round(h_q, s_fin);
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        // Valid trails the OUT entry by one clock so the digest register is offered settled.
        digest_valid_d = 1'b1;
        if (digest_valid_q && digest_ready) begin
          digest_valid_d = 1'b0;
          h_d            = IV;
          len_d          = '0;
          last_d         = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      h_q            <= IV;
      digest_q       <= '0;
      len_q          <= '0;
      rcnt_q         <= 4'd0;
      s_q            <= 4'd0;
      last_q         <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      digest_q       <= digest_d;
      len_q          <= len_d;
      rcnt_q         <= rcnt_d;
      s_q            <= s_d;
      last_q         <= last_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;

endmodule

// File: tb/tb_des_sbox_hash_core.sv
// Bench for des_sbox_hash_core: an 8-nibble/4-round instance and a 4-nibble/1-round instance checked against a table-driven model.
module tb_des_sbox_hash_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;

  logic        mv_a = 1'b0, mr_a, ml_a = 1'b0, dv_a, dr_a = 1'b0;
  logic [7:0]  mb_a = 8'h00;
  logic [31:0] dg_a;
  logic        mv_b = 1'b0, mr_b, ml_b = 1'b0, dv_b, dr_b = 1'b0;
  logic [7:0]  mb_b = 8'h00;
  logic [15:0] dg_b;
`ifdef HASH_IV_LOAD_EN
  logic        ivl_a = 1'b0, ivl_b = 1'b0;
  logic [31:0] iv_a = 32'h0;
  logic [15:0] iv_b = 16'h0;
`endif

  des_sbox_hash_core #(.NIBBLES(8), .ROUNDS(4), .IV(32'h4B71DF03)) u_a (
    .clk(clk), .rst(rst), .msg_valid(mv_a), .msg_ready(mr_a), .msg_byte(mb_a), .msg_last(ml_a),
    .digest_valid(dv_a), .digest_ready(dr_a), .digest(dg_a)
`ifdef HASH_IV_LOAD_EN
    , .iv_load(ivl_a), .iv(iv_a)
`endif
  );

  des_sbox_hash_core #(.NIBBLES(4), .ROUNDS(1), .IV(16'h4B71)) u_b (
    .clk(clk), .rst(rst), .msg_valid(mv_b), .msg_ready(mr_b), .msg_byte(mb_b), .msg_last(ml_b),
    .digest_valid(dv_b), .digest_ready(dr_b), .digest(dg_b)
`ifdef HASH_IV_LOAD_EN
    , .iv_load(ivl_b), .iv(iv_b)
`endif
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  int          s5 [64];
  logic [7:0]  msg_q [$];
  logic [63:0] exp_a [$];
  logic [63:0] exp_b [$];
  int          acc_cyc = 0;
  int          last_acc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sbox(input int x);
    return s5[(((x >> 5) & 1) * 2 + (x & 1)) * 16 + ((x >> 1) & 15)];
  endfunction

  function automatic int m6(input int b);
    return ((((b >> 3) ^ (b >> 2)) & 1) << 5) | (((b >> 1) & 1) << 4) | ((b & 1) << 3) |
           (((b >> 7) & 1) << 2) | (((b >> 6) & 1) << 1) | (((b >> 5) ^ (b >> 4)) & 1);
  endfunction

  function automatic int c6(input int c);
    return ((((c >> 7) ^ (c >> 1)) & 1) << 5) | (((c >> 3) & 1) << 4) | (((c >> 2) & 1) << 3) |
           ((((c >> 5) ^ c) & 1) << 2) | (((c >> 4) & 1) << 1) | ((c >> 6) & 1);
  endfunction

  function automatic int rotl(input int v, input int k);
    return ((v << k) | (v >> (4 - k))) & 15;
  endfunction

  function automatic logic [63:0] model(input int n, input int rounds, input logic [63:0] iv);
    int h [16];
    int t [16];
    int s;
    longint unsigned len;
    logic [63:0] res;
    for (int i = 0; i < n; i++) h[i] = int'((iv >> (4 * (n - 1 - i))) & 64'hF);
    foreach (msg_q[j]) begin
      s = sbox(m6(int'(msg_q[j])));
      for (int r = 0; r < rounds; r++) begin
        for (int i = 0; i < n; i++) t[i] = rotl(h[(i + 1) % n] ^ s, (i / 2) % 4);
        for (int i = 0; i < n; i++) h[i] = t[i];
      end
    end
    len = longint'(msg_q.size());
    if (n < 8) len = len & ((64'd1 << (8 * n)) - 1);
    res = '0;
    for (int i = 0; i < n; i++) begin
      s = sbox(c6(int'((len >> (8 * (n - 1 - i))) & 255)));
      t[i] = rotl(h[(i + 1) % n] ^ s, (i / 2) % 4);
      res = res | (64'(t[i]) << (4 * (n - 1 - i)));
    end
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit b, input logic v, input logic [7:0] d, input logic l);
    if (b) begin mv_b = v; mb_b = d; ml_b = l; end
    else begin mv_a = v; mb_a = d; ml_a = l; end
  endtask

  task automatic set_dr(input bit b, input logic v);
    if (b) dr_b = v; else dr_a = v;
  endtask

  function automatic logic rdy(input bit b);
    return b ? mr_b : mr_a;
  endfunction

  function automatic logic dvf(input bit b);
    return b ? dv_b : dv_a;
  endfunction

  function automatic logic [63:0] dgf(input bit b);
    return b ? 64'(dg_b) : 64'(dg_a);
  endfunction

  task automatic send_byte(input bit b, input logic [7:0] d, input logic l, input int gap, input int exp_low);
    int k;
    repeat (gap) begin drive(b, 1'b0, 8'h00, 1'b1); @(posedge clk); #1; end
    drive(b, 1'b1, d, l);
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy(b) && k < 100);
    if (!rdy(b)) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: msg_ready=0 want 1");
      drive(b, 1'b0, 8'h00, 1'b0);
      return;
    end
    @(posedge clk); #1;
    last_acc = acc_cyc;
    acc_cyc  = cyc;
    drive(b, 1'b0, 8'h00, 1'b0);
    if (exp_low >= 0) begin
      k = 0;
      @(negedge clk);
      while (!rdy(b) && k < 50) begin k++; @(negedge clk); end
      check("ready_low_cycles", 64'(k), 64'(exp_low));
    end
  endtask

  task automatic take_digest(input bit b, input int hold, input logic [63:0] want, input int rise);
    int k;
    if (hold == 0) set_dr(b, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!dvf(b) && k < 200);
    if (!dvf(b)) begin
      n_chk++; n_fail++;
      $display("FAIL digest_timeout: digest_valid=0 want 1");
      set_dr(b, 1'b0);
      return;
    end
    if (rise >= 0) check("digest_rise_edges", 64'(k - 1), 64'(rise));
    repeat (hold) begin @(posedge clk); #1; end
    set_dr(b, 1'b1);
    @(posedge clk); #1;
    set_dr(b, 1'b0);
    check("valid_after_take", 64'(dvf(b)), 64'd0);
    check("digest_kept", dgf(b), want);
    check("ready_after_take", 64'(rdy(b)), 64'd1);
  endtask

  // ---------------- output scoreboard ----------------
  initial begin
    logic pa, pb;
    logic [63:0] held_a, held_b;
    pa = 1'b0; pb = 1'b0; held_a = '0; held_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pa = 1'b0; pb = 1'b0;
      end else begin
        if (dv_a) begin
          if (!pa) begin
            if (exp_a.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL a_unexpected_digest: got %0h want none", dg_a);
            end else begin
              check("a_digest", 64'(dg_a), exp_a[0]);
              held_a = exp_a[0];
            end
          end else check("a_digest_hold", 64'(dg_a), held_a);
          check("a_ready_low_in_out", 64'(mr_a), 64'd0);
          if (dr_a && exp_a.size() > 0) void'(exp_a.pop_front());
        end
        pa = dv_a;
        if (dv_b) begin
          if (!pb) begin
            if (exp_b.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL b_unexpected_digest: got %0h want none", dg_b);
            end else begin
              check("b_digest", 64'(dg_b), exp_b[0]);
              held_b = exp_b[0];
            end
          end else check("b_digest_hold", 64'(dg_b), held_b);
          check("b_ready_low_in_out", 64'(mr_b), 64'd0);
          if (dr_b && exp_b.size() > 0) void'(exp_b.pop_front());
        end
        pb = dv_b;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    logic [63:0] e;
    s5 = '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
           14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
            4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
           11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3};

    repeat (2) @(posedge clk);
    #1;
    check("rst_a_ready", 64'(mr_a), 64'd1);
    check("rst_a_valid", 64'(dv_a), 64'd0);
    check("rst_a_digest", 64'(dg_a), 64'd0);
    check("rst_b_ready", 64'(mr_b), 64'd1);
    check("rst_b_digest", 64'(dg_b), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed anchors for the model.
    msg_q = {8'h00};
    check("model_a_byte00", model(8, 4, 64'h4B71DF03), 64'h1440590F);
    check("model_b_byte00", model(4, 1, 64'h4B71), 64'h74DB);

    // Single zero byte.
    exp_a.push_back(64'h1440590F);
    send_byte(1'b0, 8'h00, 1'b1, 0, -1);
    take_digest(1'b0, 2, 64'h1440590F, 6);

    // Three bytes with source gaps; digest_ready raised before valid.
    msg_q = {8'hA7, 8'h3C, 8'hF0};
    e = model(8, 4, 64'h4B71DF03);
    exp_a.push_back(e);
    for (int i = 0; i < 3; i++)
      send_byte(1'b0, msg_q[i], (i == 2), int'($urandom_range(0, 3)), (i == 2) ? -1 : 4);
    take_digest(1'b0, 0, e, 6);

    // Consumer stalls 10 cycles, then the next message goes in right after the handshake.
    msg_q = {8'h5A};
    e = model(8, 4, 64'h4B71DF03);
    exp_a.push_back(e);
    send_byte(1'b0, 8'h5A, 1'b1, 1, -1);
    k = 0;
    do begin @(negedge clk); k++; end while (!dv_a && k < 200);
    check("t3_valid_seen", 64'(dv_a), 64'd1);
    repeat (10) begin @(posedge clk); #1; end
    exp_a.push_back(64'h1440590F);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    dr_a = 1'b1;
    @(posedge clk); #1;
    dr_a = 1'b0;
    check("t3_valid_clear", 64'(dv_a), 64'd0);
    check("t3_digest_kept", 64'(dg_a), e);
    @(negedge clk);
    check("t3_ready_after_hs", 64'(mr_a), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("t3_accepted_next", 64'(mr_a), 64'd0);
    take_digest(1'b0, 1, 64'h1440590F, -1);

    // Reset during the rounds of the second byte.
    send_byte(1'b0, 8'h11, 1'b0, 0, 4);
    send_byte(1'b0, 8'h22, 1'b0, 0, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t4_rst_ready", 64'(mr_a), 64'd1);
    check("t4_rst_valid", 64'(dv_a), 64'd0);
    check("t4_rst_digest", 64'(dg_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.push_back(64'h1440590F);
    send_byte(1'b0, 8'h00, 1'b1, 0, -1);
    take_digest(1'b0, 0, 64'h1440590F, 6);

    // Narrow instance: single byte, then a 300-byte message streamed back to back.
    exp_b.push_back(64'h74DB);
    send_byte(1'b1, 8'h00, 1'b1, 0, -1);
    take_digest(1'b1, 1, 64'h74DB, 3);
    msg_q.delete();
    for (int i = 0; i < 300; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    e = model(4, 1, 64'h4B71);
    exp_b.push_back(e);
    for (int i = 0; i < 300; i++) begin
      send_byte(1'b1, msg_q[i], (i == 299), 0, -1);
      if (i > 0) check("b_cycles_per_byte", 64'(acc_cyc - last_acc), 64'd2);
    end
    take_digest(1'b1, 3, e, 3);

`ifdef HASH_IV_LOAD_EN
    // Loaded start value for one message, then back to the parameter IV.
    ivl_a = 1'b1; iv_a = 32'h0;
    @(posedge clk); #1;
    ivl_a = 1'b0;
    msg_q = {8'h00};
    e = model(8, 4, 64'h0);
    exp_a.push_back(e);
    send_byte(1'b0, 8'h00, 1'b1, 0, -1);
    take_digest(1'b0, 0, e, 6);
    exp_a.push_back(64'h1440590F);
    send_byte(1'b0, 8'h00, 1'b1, 0, -1);
    ivl_a = 1'b1; iv_a = 32'hFFFFFFFF;
    @(posedge clk); #1;
    ivl_a = 1'b0;
    take_digest(1'b0, 0, 64'h1440590F, -1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("a_all_digests_seen", 64'(exp_a.size()), 64'd0);
    check("b_all_digests_seen", 64'(exp_b.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
